// File: rtl/fht_unload_if.sv
`default_nettype none
// ============================================================================
// Module      : fht_unload_if
// Description : Bundle of the unload engine's control, bank-read and sample
//               stream signals. The slave modport is the unload engine. The
//               master modport is its environment: controller, bank RAMs and
//               downstream consumer.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Signals (directions as seen by the slave):
//   iSTART    in   one-cycle pulse, results ready, begin unload
//   iBANK_SEL in   result set to read (0 = set A, 1 = set B)
//   oBANK_SEL out  registered bank-set select for the RAM read mux
//   oADDR_RD  out  row address shared by all four banks
//   oRD_EN    out  bank read strobe
//   iDATA_0..3 in  bank read data, RD_LAT cycles after oRD_EN
//   oDATA     out  serialized output sample
//   oINDEX    out  point index of oDATA
//   oVALID    out  oDATA/oINDEX valid
//   iREADY    in   downstream accepts the sample
//   oBUSY     out  unload in progress
//   oDONE     out  one-cycle pulse after the last sample has transferred
// ============================================================================
interface fht_unload_if #(
  parameter int A_BIT = 8,
  parameter int D_BIT = 16
) ();
  logic               iSTART;
  logic               iBANK_SEL;
  logic               oBANK_SEL;
  logic [A_BIT-1:0]   oADDR_RD;
  logic               oRD_EN;
  logic [D_BIT-1:0]   iDATA_0;
  logic [D_BIT-1:0]   iDATA_1;
  logic [D_BIT-1:0]   iDATA_2;
  logic [D_BIT-1:0]   iDATA_3;
  logic [D_BIT-1:0]   oDATA;
  logic [A_BIT+1:0]   oINDEX;
  logic               oVALID;
  logic               iREADY;
  logic               oBUSY;
  logic               oDONE;

  modport master (
    output iSTART, iBANK_SEL, iDATA_0, iDATA_1, iDATA_2, iDATA_3, iREADY,
    input  oBANK_SEL, oADDR_RD, oRD_EN, oDATA, oINDEX, oVALID, oBUSY, oDONE
  );

  modport slave (
    input  iSTART, iBANK_SEL, iDATA_0, iDATA_1, iDATA_2, iDATA_3, iREADY,
    output oBANK_SEL, oADDR_RD, oRD_EN, oDATA, oINDEX, oVALID, oBUSY, oDONE
  );
endinterface
`default_nettype wire

// File: rtl/fht_unload.sv
`default_nettype none
// ============================================================================
// Module      : fht_unload
// Description : FHT result read-out engine. Reads the four result banks row
//               by row in natural point order (point k lives in bank k[1:0],
//               row k[A_BIT+1:2]) and serializes them onto one valid/ready
//               sample stream. A two-entry row buffer with credit-based read
//               issue absorbs RAM latency and downstream backpressure.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports:
//   iCLK    in  clock
//   iRESET  in  asynchronous active-high reset, aborts an unload at once
//   bus     fht_unload_if.slave, see the interface header for its signals
// Parameters:
//   A_BIT   bank row-address width, N = 2^(A_BIT+2) points (A_BIT >= 1)
//   D_BIT   signed sample width
//   RD_LAT  bank read latency in cycles (1..3)
//   SCALE   output right-shift with round-half-up
// Optional feature macro:
//   FHT_UNLOAD_SCALE_EN  enables the SCALE rounding stage on oDATA. When it
//                        is undefined oDATA is the raw bank sample.
// ============================================================================
module fht_unload #(
  parameter int A_BIT  = 8,
  parameter int D_BIT  = 16,
  parameter int RD_LAT = 1,
  parameter int SCALE  = 0
) (
  input  logic        iCLK,
  input  logic        iRESET,
  fht_unload_if.slave bus
);

  localparam int             IW       = A_BIT + 2;
  localparam logic [A_BIT-1:0] LAST_ROW = '1;
  localparam logic [IW-1:0]  LAST_IDX = '1;

`ifdef FHT_UNLOAD_SCALE_EN
  localparam int SHIFT = SCALE;
`else
  // Raw samples: a zero shift turns the rounding path into a pass-through.
  localparam int SHIFT = SCALE * 0;
`endif

  localparam int               RND_POS = (SHIFT > 0) ? SHIFT - 1 : 0;
  localparam logic signed [D_BIT:0] RND = (SHIFT > 0) ? ((D_BIT+1)'(1) << RND_POS) : '0;

  // Round-half-up arithmetic shift at D_BIT+1 bits, saturated to D_BIT.
  function automatic logic [D_BIT-1:0] round_sample(input logic [D_BIT-1:0] s);
    logic signed [D_BIT:0] sum;
    logic signed [D_BIT:0] shr;
    sum = $signed({s[D_BIT-1], s}) + RND;
    shr = sum >>> SHIFT;
    if (shr[D_BIT] != shr[D_BIT-1])
      round_sample = shr[D_BIT] ? {1'b1, {(D_BIT-1){1'b0}}} : {1'b0, {(D_BIT-1){1'b1}}};
    else
      round_sample = shr[D_BIT-1:0];
  endfunction

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_t;

  state_t                       state;
  logic                         bank_sel;
  logic [A_BIT-1:0]             row_cnt;
  logic [A_BIT-1:0]             addr_rd;
  logic                         rd_en;
  logic [RD_LAT-1:0]            rd_pipe;
  logic [1:0]                   used;       // rows in flight + rows buffered
  logic [1:0][3:0][D_BIT-1:0]   buf_data;
  logic [1:0]                   buf_full;
  logic                         head;
  logic                         tail;
  logic [1:0]                   lane;
  logic                         valid;
  logic [D_BIT-1:0]             data;
  logic [IW-1:0]                index;
  logic                         busy;
  logic                         done;

  logic                         xfer;
  logic                         free_row;
  logic                         cap;
  logic                         issue;
  logic [1:0]                   used_eff;
  logic [RD_LAT-1:0]            rd_pipe_n;
  logic [1:0][3:0][D_BIT-1:0]   buf_n;
  logic [1:0]                   full_n;
  logic                         head_n;
  logic                         tail_n;
  logic [1:0]                   lane_n;
  logic [D_BIT-1:0]             head_sample;

  assign xfer     = valid & bus.iREADY;
  assign free_row = xfer & (lane == 2'd3);
  assign cap      = rd_pipe[RD_LAT-1];
  // A row freed this cycle hands its credit straight to the next read.
  assign used_eff = used - {1'b0, free_row};
  assign issue    = ((state == IDLE) && bus.iSTART) ||
                    ((state == RUN) && (used_eff < 2'd2));

  // Next buffer state. The registered output stage is loaded from it so
  // oVALID/oDATA reflect the head entry with no extra latency.
  always_comb begin
    full_n    = buf_full;
    head_n    = head;
    tail_n    = tail;
    lane_n    = lane;
    buf_n     = buf_data;
    rd_pipe_n = rd_pipe << 1;
    rd_pipe_n[0] = rd_en;
    if (free_row) begin
      full_n[head] = 1'b0;
      head_n       = ~head;
    end
    if (xfer)
      lane_n = lane + 2'd1;
    // The credit rule guarantees the tail entry is free whenever data returns.
    if (cap) begin
      buf_n[tail]  = {bus.iDATA_3, bus.iDATA_2, bus.iDATA_1, bus.iDATA_0};
      full_n[tail] = 1'b1;
      tail_n       = ~tail;
    end
    head_sample = buf_n[head_n][lane_n];
  end

  always_ff @(posedge iCLK or posedge iRESET) begin
    if (iRESET) begin
      state    <= IDLE;
      bank_sel <= 1'b0;
      row_cnt  <= '0;
      addr_rd  <= '0;
      rd_en    <= 1'b0;
      rd_pipe  <= '0;
      used     <= 2'd0;
      buf_data <= '0;
      buf_full <= 2'b00;
      head     <= 1'b0;
      tail     <= 1'b0;
      lane     <= 2'd0;
      valid    <= 1'b0;
      data     <= '0;
      index    <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      rd_pipe  <= rd_pipe_n;
      buf_data <= buf_n;
      buf_full <= full_n;
      head     <= head_n;
      tail     <= tail_n;
      lane     <= lane_n;
      valid    <= full_n[head_n];
      data     <= round_sample(head_sample);
      used     <= used_eff + {1'b0, issue};
      if (xfer)
        index <= (index == LAST_IDX) ? '0 : index + 1'b1;
      done  <= 1'b0;
      rd_en <= 1'b0;

      case (state)
        IDLE: begin
          if (bus.iSTART) begin
            bank_sel <= bus.iBANK_SEL;
            rd_en    <= 1'b1;
            addr_rd  <= '0;
            row_cnt  <= {{(A_BIT-1){1'b0}}, 1'b1};
            index    <= '0;
            busy     <= 1'b1;
            state    <= RUN;
          end
        end
        RUN: begin
          if (issue) begin
            rd_en   <= 1'b1;
            addr_rd <= row_cnt;
            // The counter holds on the last row; it is cleared on the next start.
            if (row_cnt == LAST_ROW)
              state <= DRAIN;
            else
              row_cnt <= row_cnt + 1'b1;
          end
        end
        DRAIN: begin
          if (xfer && (index == LAST_IDX)) begin
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.oBANK_SEL = bank_sel;
  assign bus.oADDR_RD  = addr_rd;
  assign bus.oRD_EN    = rd_en;
  assign bus.oDATA     = data;
  assign bus.oINDEX    = index;
  assign bus.oVALID    = valid;
  assign bus.oBUSY     = busy;
  assign bus.oDONE     = done;

endmodule
`default_nettype wire

// File: tb/tb_fht_unload.sv
`default_nettype none
// ============================================================================
// Module      : tb_fht_unload
// Description : Directed self-checking bench for fht_unload. Three instances
//               (RD_LAT=1, RD_LAT=3, SCALE=2), all with A_BIT=2 (N=16), each
//               fed by a bench bank-RAM model of matching latency.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fht_unload;
  localparam int A = 2;
  localparam int D = 16;
  localparam int N = 16;
  localparam logic [D-1:0] JUNK = 16'hDEAD;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic start = 1'b0;
  logic bank_sel = 1'b0;
  logic ready = 1'b0;
  int   sel = 0;
  int   pat = 0;
  bit   scaled_exp = 1'b0;
  logic bsel_run = 1'b0;
  int   checks = 0;
  int   failures = 0;

  fht_unload_if #(.A_BIT(A), .D_BIT(D)) bus0 ();
  fht_unload_if #(.A_BIT(A), .D_BIT(D)) bus1 ();
  fht_unload_if #(.A_BIT(A), .D_BIT(D)) bus2 ();

  fht_unload #(.A_BIT(A), .D_BIT(D), .RD_LAT(1), .SCALE(0)) u_lat1 (.iCLK(clk), .iRESET(rst), .bus(bus0.slave));
  fht_unload #(.A_BIT(A), .D_BIT(D), .RD_LAT(3), .SCALE(0)) u_lat3 (.iCLK(clk), .iRESET(rst), .bus(bus1.slave));
  fht_unload #(.A_BIT(A), .D_BIT(D), .RD_LAT(1), .SCALE(2)) u_scl2 (.iCLK(clk), .iRESET(rst), .bus(bus2.slave));

  // Bank contents: pattern 0 -> set A holds k, set B holds 100+k;
  // pattern 1 -> fixed edge samples at k=0..3, zero elsewhere.
  function automatic logic [D-1:0] mem_val(input int p, input logic bs, input int k);
    if (p == 0) return bs ? 16'(100 + k) : 16'(k);
    case (k)
      0:       return 16'd5;
      1:       return 16'hFFFB;
      2:       return 16'h7FFF;
      3:       return 16'h8000;
      default: return 16'd0;
    endcase
  endfunction

  function automatic logic [D-1:0] exp_val(input int n);
    if (scaled_exp) begin
      case (n)
        0:       return 16'd1;
        1:       return 16'hFFFF;
        2:       return 16'h2000;
        3:       return 16'hE000;
        default: return 16'd0;
      endcase
    end
    return mem_val(pat, bsel_run, n);
  endfunction

  logic [D-1:0] q0 [4];
  logic [D-1:0] q1a [4];
  logic [D-1:0] q1b [4];
  logic [D-1:0] q1c [4];
  logic [D-1:0] q2 [4];

  always @(posedge clk) begin
    for (int b = 0; b < 4; b++) begin
      q0[b]  <= bus0.oRD_EN ? mem_val(pat, bus0.oBANK_SEL, int'(bus0.oADDR_RD) * 4 + b) : JUNK;
      q1a[b] <= bus1.oRD_EN ? mem_val(pat, bus1.oBANK_SEL, int'(bus1.oADDR_RD) * 4 + b) : JUNK;
      q1b[b] <= q1a[b];
      q1c[b] <= q1b[b];
      q2[b]  <= bus2.oRD_EN ? mem_val(pat, bus2.oBANK_SEL, int'(bus2.oADDR_RD) * 4 + b) : JUNK;
    end
  end

  assign bus0.iSTART = start && (sel == 0);
  assign bus1.iSTART = start && (sel == 1);
  assign bus2.iSTART = start && (sel == 2);
  assign bus0.iBANK_SEL = bank_sel;
  assign bus1.iBANK_SEL = bank_sel;
  assign bus2.iBANK_SEL = bank_sel;
  assign bus0.iREADY = ready;
  assign bus1.iREADY = ready;
  assign bus2.iREADY = ready;
  assign bus0.iDATA_0 = q0[0];
  assign bus0.iDATA_1 = q0[1];
  assign bus0.iDATA_2 = q0[2];
  assign bus0.iDATA_3 = q0[3];
  assign bus1.iDATA_0 = q1c[0];
  assign bus1.iDATA_1 = q1c[1];
  assign bus1.iDATA_2 = q1c[2];
  assign bus1.iDATA_3 = q1c[3];
  assign bus2.iDATA_0 = q2[0];
  assign bus2.iDATA_1 = q2[1];
  assign bus2.iDATA_2 = q2[2];
  assign bus2.iDATA_3 = q2[3];

  logic         obs_valid, obs_done, obs_busy, obs_rd_en, obs_bsel;
  logic [A-1:0] obs_addr;
  logic [D-1:0] obs_data;
  logic [A+1:0] obs_index;

  always_comb begin
    obs_valid = bus0.oVALID; obs_done = bus0.oDONE; obs_busy = bus0.oBUSY;
    obs_rd_en = bus0.oRD_EN; obs_bsel = bus0.oBANK_SEL; obs_addr = bus0.oADDR_RD;
    obs_data  = bus0.oDATA;  obs_index = bus0.oINDEX;
    if (sel == 1) begin
      obs_valid = bus1.oVALID; obs_done = bus1.oDONE; obs_busy = bus1.oBUSY;
      obs_rd_en = bus1.oRD_EN; obs_bsel = bus1.oBANK_SEL; obs_addr = bus1.oADDR_RD;
      obs_data  = bus1.oDATA;  obs_index = bus1.oINDEX;
    end else if (sel == 2) begin
      obs_valid = bus2.oVALID; obs_done = bus2.oDONE; obs_busy = bus2.oBUSY;
      obs_rd_en = bus2.oRD_EN; obs_bsel = bus2.oBANK_SEL; obs_addr = bus2.oADDR_RD;
      obs_data  = bus2.oDATA;  obs_index = bus2.oINDEX;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // mode 0: ready always 1; mode 1: 1,0,1,0...; mode 2: low until cycle 20.
  function automatic logic ready_for(input int mode, input int c);
    case (mode)
      0:       return 1'b1;
      1:       return (c % 2) == 0;
      default: return c >= 20;
    endcase
  endfunction

  // Pulses start on the selected instance (cycle 0) and observes ncyc cycles.
  task automatic run_stream(input string tag, input logic bs, input int mode,
                            input int restart_at, input int ncyc,
                            output int done_cyc, output int rd_early);
    int n = 0;
    int rd_total = 0;
    int outst = 0;
    int max_out = 0;
    int done_cnt = 0;
    bit hold = 1'b0;
    bit pulsed = 1'b0;
    logic [D-1:0] hd = '0;
    logic [A+1:0] hi = '0;
    done_cyc = -1;
    rd_early = 0;
    bsel_run = bs;
    bank_sel = bs;
    ready    = ready_for(mode, 0);
    start    = 1'b1;
    for (int c = 1; c <= ncyc; c++) begin
      @(posedge clk); #1;
      start    = 1'b0;
      bank_sel = bs;
      ready    = ready_for(mode, c);
      if (obs_rd_en) begin
        rd_total++;
        outst++;
        if (c <= 20) rd_early++;
      end
      if (outst > max_out) max_out = outst;
      if (obs_done) begin
        done_cnt++;
        done_cyc = c;
      end
      if (hold) check({tag, " hold"}, {obs_valid, obs_data, obs_index}, {1'b1, hd, hi});
      hold = 1'b0;
      if (obs_valid && ready) begin
        if (n < N) begin
          check({tag, " data"}, obs_data, exp_val(n));
          check({tag, " index"}, obs_index, n);
        end
        if (n % 4 == 3) outst--;
        n++;
      end else if (obs_valid) begin
        hold = 1'b1;
        hd   = obs_data;
        hi   = obs_index;
      end
      if (restart_at >= 0 && n == restart_at && !pulsed) begin
        start    = 1'b1;
        bank_sel = ~bs;
        pulsed   = 1'b1;
      end
    end
    start = 1'b0;
    check({tag, " transfers"}, n, N);
    check({tag, " done pulses"}, done_cnt, 1);
    check({tag, " reads"}, rd_total, 4);
    check({tag, " outstanding le 2"}, max_out <= 2, 1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int dc;
    int re;
    bit found;
    int dones;

    // Reset state
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("reset valid", obs_valid, 0);
    check("reset done", obs_done, 0);
    check("reset busy", obs_busy, 0);
    check("reset rd_en", obs_rd_en, 0);
    check("reset addr/bsel", {obs_addr, obs_bsel}, 0);
    check("reset data/index", {obs_data, obs_index}, 0);
    rst = 1'b0;
    @(posedge clk); #1;

    // Full-rate unload of set A
    sel = 0; pat = 0;
    run_stream("setA", 1'b0, 0, -1, 24, dc, re);
    check("setA done cycle", dc, 19);
    check("setA bank_sel", obs_bsel, 0);

    // Set B with alternating backpressure
    run_stream("setB", 1'b1, 1, -1, 45, dc, re);
    check("setB bank_sel", obs_bsel, 1);

    // RD_LAT=3, downstream stalled for 20 cycles
    sel = 1;
    run_stream("lat3", 1'b0, 2, -1, 45, dc, re);
    check("lat3 early reads", re, 2);
    check("lat3 done cycle", dc, 36);

    // Second start during a busy unload is ignored
    sel = 0;
    run_stream("restart", 1'b0, 0, 5, 30, dc, re);
    check("restart done cycle", dc, 19);

    // Reset at transfer 7 aborts without oDONE
    bank_sel = 1'b0; ready = 1'b1; start = 1'b1; bsel_run = 1'b0;
    found = 1'b0;
    for (int c = 0; c < 30 && !found; c++) begin
      @(posedge clk); #1;
      start = 1'b0;
      if (obs_valid && obs_index == 4'd7) found = 1'b1;
    end
    check("abort reached index 7", found, 1);
    rst = 1'b1;
    @(posedge clk); #1;
    check("abort outputs zero",
          {obs_valid, obs_done, obs_busy, obs_rd_en, obs_addr, obs_bsel, obs_data, obs_index}, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    dones = 0;
    for (int c = 0; c < 25; c++) begin
      @(posedge clk); #1;
      if (obs_done) dones++;
    end
    check("abort no done", dones, 0);
    check("abort idle busy", obs_busy, 0);
    run_stream("post-abort", 1'b0, 0, -1, 24, dc, re);
    check("post-abort done cycle", dc, 19);

    // Edge samples: SCALE=0 passes them unchanged
    pat = 1; sel = 0;
    run_stream("raw", 1'b0, 0, -1, 24, dc, re);

    // SCALE=2 instance: rounded when the feature is built in, raw otherwise
    sel = 2;
`ifdef FHT_UNLOAD_SCALE_EN
    scaled_exp = 1'b1;
`endif
    run_stream("scale2", 1'b0, 0, -1, 24, dc, re);
    check("scale2 done cycle", dc, 19);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
